// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// Contents: data width constant and the receiver state enum.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    , RX_PARITY  = 3'd5
`endif
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
//   rx_data  : received byte, stable while rx_valid
//   rx_valid : holding register full (level)
//   rx_ready : consumer accepts when rx_valid && rx_ready
// master = receiver, slave = consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk, rst : clock, async active-high reset (both flops load RST_VAL)
//   d        : asynchronous input
//   q        : synchronized output, 2 cycles latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, 1 stop bit, mid-bit sampling by
// clock counting, one-entry holding register with valid/ready handshake.
// Optional even parity when UART_RX_PARITY_EN is defined.
//   clk, rst    : clock, async active-high reset
//   rx_in       : serial line, idle high, asynchronous
//   rx_bus      : uart_rx_if.master (rx_data, rx_valid, rx_ready)
//   rx_busy     : high whenever the receiver is not idle (registered)
//   frame_err   : 1-cycle pulse, stop bit sampled low
//   overrun_err : 1-cycle pulse, good byte dropped because register full
//   parity_err  : 1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  uart_rx_if.master  rx_bus,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state;
  logic [CW-1:0]             cnt;
  logic [3:0]                idx;
  logic [UART_DATA_BITS-1:0] shift;
  // Frame outcome, acted on one cycle after the stop sample
  logic                      done_good;
  logic                      done_frame;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad;
  logic                      done_par;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Receive FSM, delivery stage and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RX_IDLE;
      cnt             <= '0;
      idx             <= '0;
      shift           <= '0;
      done_good       <= 1'b0;
      done_frame      <= 1'b0;
      rx_busy         <= 1'b0;
      frame_err       <= 1'b0;
      overrun_err     <= 1'b0;
      rx_bus.rx_data  <= '0;
      rx_bus.rx_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad         <= 1'b0;
      done_par        <= 1'b0;
      parity_err      <= 1'b0;
`endif
    end else begin
      done_good   <= 1'b0;
      done_frame  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= (state != RX_IDLE);
`ifdef UART_RX_PARITY_EN
      done_par    <= 1'b0;
      parity_err  <= 1'b0;
      if (done_par) parity_err <= 1'b1;
`endif
      if (done_frame) frame_err <= 1'b1;

      // A same-cycle accept frees the register for the incoming byte
      if (done_good) begin
        if (!rx_bus.rx_valid || rx_bus.rx_ready) begin
          rx_bus.rx_data  <= shift;
          rx_bus.rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
        rx_bus.rx_valid <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= RX_DATA;
              idx   <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt             <= '0;
            shift[idx[2:0]] <= rx_s;
            idx             <= idx + 1'b1;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RX_STOP;
            if (^{shift, rx_s}) par_bad <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= RX_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) done_par  <= 1'b1;
              else         done_good <= 1'b1;
`else
              done_good <= 1'b1;
`endif
            end else begin
              // Parity is not reported for a framing-error frame
              state      <= RX_WAIT_HIGH;
              done_frame <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          // Hold off until the line idles so a break cannot retrigger
          cnt <= '0;
          if (rx_s) state <= RX_IDLE;
        end
        default: begin
          state <= RX_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone UART receiver: recovers 8-bit bytes from an external asynchronous serial line (8N1; optional even parity) using a clock-counted mid-bit sampler. It is the receive end for frames produced by the team's `uart` transmitter or an off-chip device, and presents each byte to the fabric through a one-entry valid/ready holding register with framing and overrun reporting.

## Interface
- `CLKS_PER_BIT`, 16 — clk cycles per serial bit; even integer ≥ 4; `HALF = CLKS_PER_BIT/2`.
- `clk  in  1` — system clock; all logic on rising edge.
- `rst  in  1` — reset, asynchronous, active-high.
- `rx_in  in  1` — serial line, idle high, asynchronous to clk.
- `rx_data  out  8` — received byte, stable while `rx_valid`.
- `rx_valid  out  1` — holding register full; level, cleared by accept.
- `rx_ready  in  1` — consumer accepts when `rx_valid && rx_ready`.
- `rx_busy  out  1` — high in any state other than IDLE.
- `frame_err  out  1` — 1-cycle pulse: stop bit sampled 0.
- `overrun_err  out  1` — 1-cycle pulse: good byte completed while holding register full and not accepted.
- `parity_err  out  1` — 1-cycle pulse; present only with `UART_RX_PARITY_EN`.

## Operation
- `rx_in` passes through a 2-flop synchronizer (flops reset to 1) giving `rx_s`. All decisions use `rx_s` only.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: bit counter `cnt`=0. When `rx_s==0` → START, `cnt<=0`.
- START: count to `HALF-1`. At `cnt==HALF-1`, sample `rx_s`: 0 → DATA, `cnt<=0`, `idx<=0`; 1 → false start, back to IDLE with no flags.
- DATA: at `cnt==CLKS_PER_BIT-1`, shift `rx_s` into `shift[idx]` (LSB first), `idx++`, `cnt<=0`. After the 8th sample → PARITY, or STOP if the macro is off.
- PARITY: sample at `cnt==CLKS_PER_BIT-1`. If `^{shift, sample} != 0`, set a sticky `par_bad` for this frame. → STOP.
- STOP: sample at `cnt==CLKS_PER_BIT-1`.
  - 1 and no `par_bad` → deliver the byte, → IDLE.
  - 1 and `par_bad` → pulse `parity_err`, discard the byte, → IDLE.
  - 0 → pulse `frame_err` and discard the byte. Parity is not reported for a framing-error frame. → WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s==1`, then → IDLE. This stops a break condition or stuck-low line from retriggering.
- Deliver rules:
  - If `!rx_valid`, or `rx_valid && rx_ready` in the same cycle: `rx_data<=shift`, `rx_valid<=1`.
  - Otherwise: keep the old byte, drop the new one, pulse `overrun_err`.
- Accept: `rx_valid && rx_ready` with no simultaneous delivery → `rx_valid<=0`. `rx_data` keeps its last value.
- `rx_ready` has no effect while `rx_valid==0`.
- Width rules:
  - `cnt` is `$clog2(CLKS_PER_BIT)` bits and never wraps past `CLKS_PER_BIT-1`.
  - `idx` is 4 bits.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun_err`=0, `parity_err`=0; state IDLE; synchronizer flops=1.
- Reset mid-frame aborts the frame immediately with no flags and no delivery; the next frame is received normally.
- Synchronizer latency: 2 cycles. Let T0 be the edge at which IDLE first sees `rx_s==0`.
- Start-bit sample at T0+HALF. Data bit i (0..7) sampled at T0+HALF+(i+1)·CLKS_PER_BIT.
- Stop sample at T0+HALF+9·CLKS_PER_BIT without parity, T0+HALF+10·CLKS_PER_BIT with parity.
- `rx_valid`, `frame_err`, `overrun_err` and `parity_err` change on the edge following the stop-sample edge.
- Error pulses are exactly 1 cycle wide.
- Back-to-back frames (stop bit directly followed by a start bit) are received without loss: the machine is in IDLE 1 cycle after the stop sample, leaving ≥ HALF-1 cycles of margin.
- `rx_busy` is registered. It is high from T0+1 until the cycle after the machine returns to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 11 bits: start, 8 data, even parity, stop.
  - The PARITY state and `parity_err` port exist.
- Undefined:
  - Frames are 10 bits (8N1).
  - No PARITY state; the `parity_err` port is omitted.

## Structure
- Shared package `uart_pkg`: state enum `uart_rx_state_t`, constant `UART_DATA_BITS=8`. The package is shared with the transmitter.
- Sub-module `sync_2ff` (1-bit, reset value parameter) for the `rx_in` synchronizer. It is reusable for other async inputs.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 0xA5 as 8N1 with `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` rises at T0+153 and drops 1 cycle later.
- Low glitch on `rx_in` of 4 cycles → state returns to IDLE at T0+8; no `rx_valid` and no flags.
- Send 0x3C with stop bit=0, then hold the line low for 40 cycles → `frame_err` pulses once, `rx_valid` stays 0, `rx_busy` stays high until the line returns high.
- Send 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11 stays, `overrun_err` pulses once at the end of frame 2. Then raise `rx_ready` for 1 cycle → `rx_valid`=0.
- Assert `rst` during data bit 3 of 0xF0, release it, then send 0x5A → no delivery for 0xF0; `rx_data`=0x5A delivered correctly.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_err` pulse, no delivery. Send 0x07 with parity bit 1 → `rx_data`=0x07 delivered.
